// File: rtl/escritura_registros.sv
// escritura_registros: write-back sequencer merging ALU and load results into the register-file write port
// through a small FIFO, with backpressure and a forwarding lookup over all pending writes.
module escritura_registros #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [4:0]    alu_dir,
    input  logic [31:0]   alu_dato,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [4:0]    mem_dir,
    input  logic [31:0]   mem_dato,
    output logic          wEnable,
    output logic [4:0]    dirEsc,
    output logic [31:0]   datoIn,
    input  logic [4:0]    cons_dir,
    output logic          cons_hit,
    output logic [31:0]   cons_dato,
    output logic [AW:0]   ocupacion
);
    logic [4:0]    r_fifo_dir  [DEPTH];
    logic [31:0]   r_fifo_dato [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;
    logic          r_we;
    logic [4:0]    r_dir;
    logic [31:0]   r_dato;
    logic [AW:0]   w_free;
    logic          w_pm;
    logic          w_pa;
    logic          w_pop;
    logic [AW-1:0] w_wa;
    logic          w_hit;
    logic [31:0]   w_dato;

    // Credit comes only from the registered count; a same-cycle pop does not free a slot.
    assign w_free    = (AW+1)'(DEPTH) - r_cnt;
    assign mem_ready = w_free != '0;
    assign alu_ready = (w_free >= (AW+1)'(2)) | ((w_free == (AW+1)'(1)) & !mem_valid);
    assign w_pm      = mem_valid & mem_ready & (|mem_dir);
    assign w_pa      = alu_valid & alu_ready & (|alu_dir);
    assign w_pop     = |r_cnt;
    assign w_wa      = r_wr + AW'(w_pm);

    always_ff @(posedge clk) begin
        if (w_pm) begin
            r_fifo_dir[r_wr]  <= mem_dir;
            r_fifo_dato[r_wr] <= mem_dato;
        end
        if (w_pa) begin
            r_fifo_dir[w_wa]  <= alu_dir;
            r_fifo_dato[w_wa] <= alu_dato;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_cnt  <= '0;
            r_we   <= 1'b0;
            r_dir  <= '0;
            r_dato <= '0;
        end else begin
            r_wr  <= r_wr + AW'(w_pm) + AW'(w_pa);
            r_rd  <= r_rd + AW'(w_pop);
            r_cnt <= r_cnt + (AW+1)'(w_pm) + (AW+1)'(w_pa) - (AW+1)'(w_pop);
            r_we  <= w_pop;
            if (w_pop) begin
                r_dir  <= r_fifo_dir[r_rd];
                r_dato <= r_fifo_dato[r_rd];
            end
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest pending value.
    always_comb begin
        w_hit  = 1'b0;
        w_dato = '0;
        if (r_we && r_dir == cons_dir) begin
            w_hit  = 1'b1;
            w_dato = r_dato;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < r_cnt && r_fifo_dir[r_rd + AW'(i)] == cons_dir) begin
                w_hit  = 1'b1;
                w_dato = r_fifo_dato[r_rd + AW'(i)];
            end
        end
        if (cons_dir == '0) begin
            w_hit  = 1'b0;
            w_dato = '0;
        end
    end

    assign wEnable   = r_we;
    assign dirEsc    = r_dir;
    assign datoIn    = r_dato;
    assign ocupacion = r_cnt;
    assign cons_hit  = w_hit;
    assign cons_dato = w_dato;
endmodule

// File: tb/tb_escritura_registros.sv
// tb_escritura_registros: directed and randomized checks of the write-back sequencer against a
// queue-based reference of pending register writes.
module tb_escritura_registros;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_dir = '0, mem_dir = '0, cons_dir = '0;
    logic [31:0] alu_dato = '0, mem_dato = '0;
    logic        wEnable, cons_hit;
    logic [4:0]  dirEsc;
    logic [31:0] datoIn, cons_dato;
    logic [2:0]  ocupacion;

    int checks = 0;
    int errors = 0;

    logic [4:0]  q_dir[$];
    logic [31:0] q_dato[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_dir = '0;
    logic [31:0] m_dato = '0;

    escritura_registros #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dir(alu_dir), .alu_dato(alu_dato),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dir(mem_dir), .mem_dato(mem_dato),
        .wEnable(wEnable), .dirEsc(dirEsc), .datoIn(datoIn),
        .cons_dir(cons_dir), .cons_hit(cons_hit), .cons_dato(cons_dato), .ocupacion(ocupacion)
    );

    always #5 clk = ~clk;

    function automatic bit exp_mem_ready();
        return q_dir.size() < DEPTH;
    endfunction

    function automatic bit exp_alu_ready();
        int f;
        f = DEPTH - q_dir.size();
        return (f >= 2) || (f == 1 && !mem_valid);
    endfunction

    function automatic logic [32:0] exp_look(input logic [4:0] d);
        if (d == 0) return '0;
        for (int i = q_dir.size() - 1; i >= 0; i--)
            if (q_dir[i] == d) return {1'b1, q_dato[i]};
        if (m_we && m_dir == d) return {1'b1, m_dato};
        return '0;
    endfunction

    // Reference: pending writes as an ordered queue; one leaves per edge, accepted ones join at the back.
    always @(posedge clk or negedge rst_n) begin
        bit am, aa;
        if (!rst_n) begin
            q_dir.delete();
            q_dato.delete();
            m_we = 1'b0;
            m_dir = '0;
            m_dato = '0;
        end else begin
            am = mem_valid && exp_mem_ready();
            aa = alu_valid && exp_alu_ready();
            if (q_dir.size() > 0) begin
                m_we = 1'b1;
                m_dir = q_dir.pop_front();
                m_dato = q_dato.pop_front();
            end else m_we = 1'b0;
            if (am && mem_dir != 0) begin q_dir.push_back(mem_dir); q_dato.push_back(mem_dato); end
            if (aa && alu_dir != 0) begin q_dir.push_back(alu_dir); q_dato.push_back(alu_dato); end
        end
    end

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (DEPTH + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #1;
        checks++; if (wEnable !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", wEnable); end
        checks++; if (dirEsc !== 5'd0) begin errors++; $display("FAIL reset_dir got %0d want 0", dirEsc); end
        checks++; if (datoIn !== 32'd0) begin errors++; $display("FAIL reset_dato got %h want 0", datoIn); end
        checks++; if (ocupacion !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", ocupacion); end
        checks++; if ({mem_ready, alu_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready got %b want 11", {mem_ready, alu_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        alu_valid = 1'b1; alu_dir = 5'd5; alu_dato = 32'h1234; cons_dir = 5'd5;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b want 1", alu_ready); end
        @(negedge clk);
        idle();
        checks++; if ({wEnable, ocupacion} !== {1'b0, 3'd1}) begin errors++; $display("FAIL single_e1 got we=%0b occ=%0d want we=0 occ=1", wEnable, ocupacion); end
        @(negedge clk);
        checks++; if ({wEnable, dirEsc, datoIn} !== {1'b1, 5'd5, 32'h1234}) begin errors++; $display("FAIL single_e2 got we=%0b dir=%0d dato=%h want 1 5 1234", wEnable, dirEsc, datoIn); end
        checks++; if ({cons_hit, cons_dato} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL single_fwd got %0b %h want 1 1234", cons_hit, cons_dato); end
        @(negedge clk);
        checks++; if (wEnable !== 1'b0) begin errors++; $display("FAIL single_e3 got we=%0b want 0", wEnable); end
    endtask

    task automatic test_dual();
        drain();
        mem_valid = 1'b1; mem_dir = 5'd3; mem_dato = 32'hAAAA;
        alu_valid = 1'b1; alu_dir = 5'd4; alu_dato = 32'hBBBB;
        #1;
        checks++; if ({mem_ready, alu_ready} !== 2'b11) begin errors++; $display("FAIL dual_ready got %b want 11", {mem_ready, alu_ready}); end
        @(negedge clk);
        idle();
        checks++; if (ocupacion !== 3'd2) begin errors++; $display("FAIL dual_occ got %0d want 2", ocupacion); end
        @(negedge clk);
        checks++; if ({wEnable, dirEsc, datoIn} !== {1'b1, 5'd3, 32'hAAAA}) begin errors++; $display("FAIL dual_first got %0b %0d %h want 1 3 aaaa", wEnable, dirEsc, datoIn); end
        @(negedge clk);
        checks++; if ({wEnable, dirEsc, datoIn} !== {1'b1, 5'd4, 32'hBBBB}) begin errors++; $display("FAIL dual_second got %0b %0d %h want 1 4 bbbb", wEnable, dirEsc, datoIn); end
    endtask

    task automatic test_back_to_back();
        int na = 1, nm = 9;
        bit blocked = 0;
        logic [4:0] got[$];
        logic [4:0] expo[$];
        drain();
        for (int c = 0; c < 40 && got.size() < 12; c++) begin
            if (c > 0) @(negedge clk);
            checks++; if (ocupacion > 3'(DEPTH) || ocupacion !== 3'(q_dir.size())) begin errors++; $display("FAIL b2b_occ got %0d want %0d", ocupacion, q_dir.size()); end
            if (wEnable) got.push_back(dirEsc);
            alu_valid = na <= 6; alu_dir = 5'(na); alu_dato = $urandom;
            mem_valid = nm <= 14; mem_dir = 5'(nm); mem_dato = $urandom;
            #1;
            checks++; if ({mem_ready, alu_ready} !== {exp_mem_ready(), exp_alu_ready()}) begin errors++; $display("FAIL b2b_ready got %b want %b", {mem_ready, alu_ready}, {exp_mem_ready(), exp_alu_ready()}); end
            if (alu_valid && !alu_ready) blocked = 1;
            if (mem_valid && mem_ready) begin expo.push_back(mem_dir); nm++; end
            if (alu_valid && alu_ready) begin expo.push_back(alu_dir); na++; end
        end
        idle();
        checks++; if (!blocked) begin errors++; $display("FAIL b2b_backpressure got none want alu_ready low once"); end
        checks++; if (got.size() != 12) begin errors++; $display("FAIL b2b_count got %0d want 12", got.size()); end
        for (int i = 0; i < got.size() && i < expo.size(); i++) begin
            checks++; if (got[i] !== expo[i]) begin errors++; $display("FAIL b2b_order[%0d] got %0d want %0d", i, got[i], expo[i]); end
        end
    endtask

    task automatic test_dir0();
        int pulses = 0;
        drain();
        alu_valid = 1'b1; alu_dir = 5'd0; alu_dato = 32'hFFFF; cons_dir = 5'd0;
        #1;
        checks++; if ({alu_ready, cons_hit, cons_dato} !== {1'b1, 1'b0, 32'd0}) begin errors++; $display("FAIL dir0_pre got rdy=%0b hit=%0b dato=%h want 1 0 0", alu_ready, cons_hit, cons_dato); end
        @(negedge clk);
        idle();
        checks++; if (ocupacion !== 3'd0) begin errors++; $display("FAIL dir0_occ got %0d want 0", ocupacion); end
        repeat (3) begin
            if (wEnable) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL dir0_we got %0d pulses want 0", pulses); end
    endtask

    task automatic test_forward();
        logic [32:0] want[4];
        want[0] = {1'b1, 32'h22}; want[1] = {1'b1, 32'h22}; want[2] = {1'b1, 32'h22}; want[3] = '0;
        drain();
        cons_dir = 5'd7;
        mem_valid = 1'b1; mem_dir = 5'd7; mem_dato = 32'h11;
        alu_valid = 1'b1; alu_dir = 5'd7; alu_dato = 32'h22;
        #1;
        checks++; if (cons_hit !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle got %0b want 0", cons_hit); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle();
            #1;
            checks++; if ({cons_hit, cons_dato} !== want[k]) begin errors++; $display("FAIL fwd_e%0d got %0b %h want %0b %h", k + 1, cons_hit, cons_dato, want[k][32], want[k][31:0]); end
        end
    endtask

    task automatic test_random();
        logic [32:0] l;
        drain();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++; if ({wEnable, ocupacion} !== {m_we, 3'(q_dir.size())}) begin errors++; $display("FAIL rnd_state c=%0d got we=%0b occ=%0d want %0b %0d", c, wEnable, ocupacion, m_we, q_dir.size()); end
            checks++; if ({dirEsc, datoIn} !== {m_dir, m_dato}) begin errors++; $display("FAIL rnd_out c=%0d got %0d %h want %0d %h", c, dirEsc, datoIn, m_dir, m_dato); end
            alu_valid = $urandom_range(0, 3) != 0; alu_dir = 5'($urandom_range(0, 7)); alu_dato = $urandom;
            mem_valid = $urandom_range(0, 2) != 0; mem_dir = 5'($urandom_range(0, 7)); mem_dato = $urandom;
            cons_dir = 5'($urandom_range(0, 7));
            #1;
            l = exp_look(cons_dir);
            checks++; if ({mem_ready, alu_ready} !== {exp_mem_ready(), exp_alu_ready()}) begin errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, {mem_ready, alu_ready}, {exp_mem_ready(), exp_alu_ready()}); end
            checks++; if ({cons_hit, cons_dato} !== l) begin errors++; $display("FAIL rnd_fwd c=%0d dir=%0d got %0b %h want %0b %h", c, cons_dir, cons_hit, cons_dato, l[32], l[31:0]); end
        end
        idle();
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        drain();
        mem_valid = 1'b1; mem_dir = 5'd1; mem_dato = 32'h1;
        alu_valid = 1'b1; alu_dir = 5'd2; alu_dato = 32'h2;
        @(negedge clk);
        mem_dir = 5'd3; alu_dir = 5'd4;
        @(negedge clk);
        idle();
        checks++; if (ocupacion !== 3'd3) begin errors++; $display("FAIL arst_pre got %0d want 3", ocupacion); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({wEnable, ocupacion, dirEsc} !== {1'b0, 3'd0, 5'd0}) begin errors++; $display("FAIL arst_now got we=%0b occ=%0d dir=%0d want 0 0 0", wEnable, ocupacion, dirEsc); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (wEnable) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL arst_after got %0d writes want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_back_to_back();
        test_dir0();
        test_forward();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
